// File: rtl/ula_issuer.sv
// Command-side initiator for the ULA: screens opcodes, drives the ULA inputs,
// waits out its registered latency and returns the result with a status code.
//
// state     | meaning
// S_IDLE    | ready for a command
// S_ISSUE   | ULA inputs stable, first latency edge
// S_WAIT    | counting down the remaining ULA latency
// S_CAPTURE | ULA result valid, registered into _res_data
// S_DONE    | result presented, waiting for _res_ready
module ula_issuer #(
  parameter int WIDTH   = 32,
  parameter int ULA_LAT = 1
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _cmd_valid,
  output logic             _cmd_ready,
  input  logic [3:0]       _cmd_op,
  input  logic [WIDTH-1:0] _cmd_a,
  input  logic [WIDTH-1:0] _cmd_b,
  output logic [WIDTH-1:0] _ula_op1,
  output logic [WIDTH-1:0] _ula_op2,
  output logic [3:0]       _ula_opcao,
  input  logic [WIDTH-1:0] _ula_result,
  output logic             _res_valid,
  input  logic             _res_ready,
  output logic [WIDTH-1:0] _res_data,
  output logic [1:0]       _res_err,
  output logic             _busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(ULA_LAT - 1);
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op1_d, op2_d, res_data_d;
  logic [3:0]       opcao_d;
  logic             res_valid_d;
  logic [1:0]       res_err_d;
  logic             op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (_cmd_op)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  assign _cmd_ready = (state_q == S_IDLE) && !_reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = _ula_op1;
    op2_d       = _ula_op2;
    opcao_d     = _ula_opcao;
    res_valid_d = _res_valid;
    res_data_d  = _res_data;
    res_err_d   = _res_err;
    case (state_q)
      S_IDLE: begin
        if (_cmd_valid) begin
          if (!op_legal) begin
            res_data_d  = '0;
            res_err_d   = ERR_ILL;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (_cmd_op == 4'b0001 && _cmd_b == '0) begin
            res_data_d  = '1;
            res_err_d   = ERR_DIV0;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            op1_d   = _cmd_a;
            op2_d   = _cmd_b;
            opcao_d = _cmd_op;
            cnt_d   = LAT_M1;
            state_d = S_ISSUE;
          end
        end
      end
      // The ULA samples the opcode on the edge entering CAPTURE, so it can be
      // dropped on that same edge and the ULA holds its result afterwards.
      S_ISSUE: begin
        if (cnt_q == '0) begin
          opcao_d = '0;
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          opcao_d = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        res_data_d  = _ula_result;
        res_err_d   = ERR_OK;
        opcao_d     = '0;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      _ula_op1   <= '0;
      _ula_op2   <= '0;
      _ula_opcao <= '0;
      _res_valid <= 1'b0;
      _res_data  <= '0;
      _res_err   <= ERR_OK;
      _busy      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      _ula_op1   <= op1_d;
      _ula_op2   <= op2_d;
      _ula_opcao <= opcao_d;
      _res_valid <= res_valid_d;
      _res_data  <= res_data_d;
      _res_err   <= res_err_d;
      _busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ula_issuer.sv
// Bench for ula_issuer: behavioural ULA models at latency 1 and 3, scoreboard
// of expected {data, err} pushed at accept and popped at result handoff.
module tb_ula_issuer;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cmd_valid, res_ready, cmd_ready, res_valid, busy;
  logic [3:0]   cmd_op, ula_opcao;
  logic [W-1:0] cmd_a, cmd_b, ula_op1, ula_op2, ula_result, res_data;
  logic [1:0]   res_err;

  logic         rst_3, cmd_valid_3, res_ready_3, cmd_ready_3, res_valid_3, busy_3;
  logic [3:0]   cmd_op_3, ula_opcao_3;
  logic [W-1:0] cmd_a_3, cmd_b_3, ula_op1_3, ula_op2_3, ula_result_3, res_data_3;
  logic [1:0]   res_err_3;

  ula_issuer #(.WIDTH(W), .ULA_LAT(1)) dut (
    ._clock(clk), ._reset(rst), ._cmd_valid(cmd_valid), ._cmd_ready(cmd_ready),
    ._cmd_op(cmd_op), ._cmd_a(cmd_a), ._cmd_b(cmd_b),
    ._ula_op1(ula_op1), ._ula_op2(ula_op2), ._ula_opcao(ula_opcao),
    ._ula_result(ula_result), ._res_valid(res_valid), ._res_ready(res_ready),
    ._res_data(res_data), ._res_err(res_err), ._busy(busy)
  );

  ula_issuer #(.WIDTH(W), .ULA_LAT(3)) dut3 (
    ._clock(clk), ._reset(rst_3), ._cmd_valid(cmd_valid_3), ._cmd_ready(cmd_ready_3),
    ._cmd_op(cmd_op_3), ._cmd_a(cmd_a_3), ._cmd_b(cmd_b_3),
    ._ula_op1(ula_op1_3), ._ula_op2(ula_op2_3), ._ula_opcao(ula_opcao_3),
    ._ula_result(ula_result_3), ._res_valid(res_valid_3), ._res_ready(res_ready_3),
    ._res_data(res_data_3), ._res_err(res_err_3), ._busy(busy_3)
  );

  function automatic logic [W-1:0] ula_f(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'b0001: ula_f = (y != '0) ? x / y : '1;
      4'b0010: ula_f = x * y;
      4'b0100: ula_f = x - y;
      4'b1000: ula_f = x + y;
      default: ula_f = '0;
    endcase
  endfunction

  // Registered ULA: computes while an opcode is present, otherwise holds.
  logic [W-1:0] u1 = '0;
  logic [W-1:0] u3a = '0, u3b = '0, u3c = '0;
  always @(posedge clk) begin
    if (ula_opcao != 4'b0000) u1 <= ula_f(ula_opcao, ula_op1, ula_op2);
    if (ula_opcao_3 != 4'b0000) u3a <= ula_f(ula_opcao_3, ula_op1_3, ula_op2_3);
    u3b <= u3a;
    u3c <= u3b;
  end
  assign ula_result   = u1;
  assign ula_result_3 = u3c;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [W+1:0] sb[$];
  logic [W+1:0] sb3[$];
  logic [W+1:0] e1, e3;
  int opc_total = 0;
  int valid3_cnt = 0;

  always @(negedge clk) begin
    if (ula_opcao != 4'b0000) opc_total++;
    if (res_valid_3) valid3_cnt++;
    if (res_valid && res_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e1 = sb.pop_front();
        chk("res_data", res_data, e1[W+1:2]);
        chk("res_err", res_err, e1[1:0]);
      end
    end
    if (res_valid_3 && res_ready_3) begin
      chk("sb3_nonempty", 64'(sb3.size() != 0), 64'd1);
      if (sb3.size() != 0) begin
        e3 = sb3.pop_front();
        chk("res_data_3", res_data_3, e3[W+1:2]);
        chk("res_err_3", res_err_3, e3[1:0]);
      end
    end
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic [1:0]   e;
    int           hold;
  } vec_t;

  // Latency is counted in edges after the accept edge: error results are
  // registered on the accept edge itself, legal ones appear ULA_LAT+1 edges later.
  task automatic issue(input vec_t v);
    int n, lat, opc0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait", n, 0);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
    @(posedge clk); #1;
    opc0 = opc_total;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom;
    sb.push_back({v.d, v.e});
    res_ready = (v.hold == 0);
    chk("busy", busy, 1);
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, (v.e == 2'b00) ? 2 : 0);
    for (int i = 0; i < v.hold; i++) begin
      chk("hold_data", res_data, v.d);
      chk("hold_err", res_err, v.e);
      chk("hold_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("handoff_valid", res_valid, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("ula_cycles", opc_total - opc0, (v.e == 2'b00) ? 1 : 0);
  endtask

  vec_t tbl[11];

  initial begin
    int n;
    tbl = '{
      '{4'b1000, 32'd7,        32'd5,        32'd12,         2'b00, 0},
      '{4'b0100, 32'd3,        32'd5,        32'hFFFF_FFFE,  2'b00, 0},
      '{4'b0010, 32'h1_0000,   32'h1_0000,   32'd0,          2'b00, 0},
      '{4'b0001, 32'd100,      32'd7,        32'd14,         2'b00, 0},
      '{4'b0001, 32'd9,        32'd0,        32'hFFFF_FFFF,  2'b01, 0},
      '{4'b0000, 32'd4,        32'd2,        32'd0,          2'b10, 0},
      '{4'b0011, 32'd4,        32'd2,        32'd0,          2'b10, 0},
      '{4'b1111, 32'd4,        32'd2,        32'd0,          2'b10, 0},
      '{4'b1000, 32'hFFFF_FFFF, 32'd2,       32'd1,          2'b00, 0},
      '{4'b1000, 32'd20,       32'd22,       32'd42,         2'b00, 5},
      '{4'b0010, 32'd6,        32'd7,        32'd42,         2'b00, 0}
    };
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    rst_3 = 1'b1; cmd_valid_3 = 1'b0; cmd_op_3 = '0; cmd_a_3 = '0; cmd_b_3 = '0; res_ready_3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_err", res_err, 0);
    chk("rst_op1", ula_op1, 0);
    chk("rst_opcao", ula_opcao, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0; rst_3 = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);

    foreach (tbl[i]) issue(tbl[i]);

    // Command offered during the DONE handoff must wait for IDLE.
    cmd_valid = 1'b1; cmd_op = 4'b1000; cmd_a = 32'd2; cmd_b = 32'd3;
    @(posedge clk); #1;
    sb.push_back({32'd5, 2'b00});
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("ovl_lat1", n, 2);
    cmd_valid = 1'b1; cmd_op = 4'b0100; cmd_a = 32'd10; cmd_b = 32'd4; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("ovl_not_taken", busy, 0);
    chk("ovl_idle_ready", cmd_ready, 1);
    @(posedge clk); #1;
    sb.push_back({32'd6, 2'b00});
    cmd_valid = 1'b0;
    chk("ovl_taken", busy, 1);
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("ovl_lat2", n, 2);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset during WAIT on the latency-3 instance drops the command.
    cmd_valid_3 = 1'b1; cmd_op_3 = 4'b1000; cmd_a_3 = 32'd5; cmd_b_3 = 32'd6;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    @(posedge clk); #1;
    chk("r3_wait_busy", busy_3, 1);
    chk("r3_wait_opcao", ula_opcao_3, 4'b1000);
    rst_3 = 1'b1;
    @(posedge clk); #1;
    rst_3 = 1'b0;
    chk("r3_valid", res_valid_3, 0);
    chk("r3_opcao", ula_opcao_3, 0);
    chk("r3_busy", busy_3, 0);
    chk("r3_cmd_ready", cmd_ready_3, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("r3_no_result", valid3_cnt, 0);
    cmd_valid_3 = 1'b1; cmd_op_3 = 4'b1000; cmd_a_3 = 32'd1; cmd_b_3 = 32'd1;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    sb3.push_back({32'd2, 2'b00});
    n = 0;
    while (!res_valid_3 && n < 20) begin @(posedge clk); #1; n++; end
    chk("r3_latency", n, 4);
    @(posedge clk); #1;
    chk("r3_handoff", res_valid_3, 0);
    chk("r3_one_result", valid3_cnt, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("sb3_drained", sb3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
